// File: rtl/accum_wr_scheduler_if.sv
// Job-control / row-stream bundle for the accumulator-table write scheduler.
// The master drives start, config and row_valid; the slave returns the write stream and status.
interface accum_wr_scheduler_if #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16
);
  localparam int ROW_W = $clog2(SYS_ARR_ROWS);
  localparam int M_W   = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS);
  localparam int N_W   = $clog2(MAX_OUT_COLS / SYS_ARR_COLS);

  logic             start;
  logic [M_W-1:0]   cfg_last_m;
  logic [N_W-1:0]   cfg_last_n;
  logic             row_valid;
  logic             wr_en;
  logic [ROW_W-1:0] sub_row;
  logic [M_W-1:0]   submat_m;
  logic [N_W-1:0]   submat_n;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, cfg_last_m, cfg_last_n, row_valid,
    input  wr_en, sub_row, submat_m, submat_n, busy, done, err
  );

  modport slave (
    input  start, cfg_last_m, cfg_last_n, row_valid,
    output wr_en, sub_row, submat_m, submat_n, busy, done, err
  );
endinterface

// File: rtl/accum_wr_scheduler.sv
// Walks sub_row (innermost), submat_n, submat_m over one output-matrix job and issues one
// registered accumulator-table write per valid column-0 result row.
module accum_wr_scheduler #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  accum_wr_scheduler_if.slave  bus
);
  localparam int ROW_W = $clog2(SYS_ARR_ROWS);
  localparam int M_W   = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS);
  localparam int N_W   = $clog2(MAX_OUT_COLS / SYS_ARR_COLS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SYS_ARR_ROWS - 1);

  logic [1:0]       state_q,    state_d;
  logic [ROW_W-1:0] row_q,      row_d;
  logic [N_W-1:0]   n_q,        n_d;
  logic [M_W-1:0]   m_q,        m_d;
  logic [M_W-1:0]   last_m_q,   last_m_d;
  logic [N_W-1:0]   last_n_q,   last_n_d;
  logic             wr_en_q,    wr_en_d;
  logic [ROW_W-1:0] sub_row_q,  sub_row_d;
  logic [M_W-1:0]   submat_m_q, submat_m_d;
  logic [N_W-1:0]   submat_n_q, submat_n_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    n_d        = n_q;
    m_d        = m_q;
    last_m_d   = last_m_q;
    last_n_d   = last_n_q;
    wr_en_d    = 1'b0;
    sub_row_d  = sub_row_q;
    submat_m_d = submat_m_q;
    submat_n_d = submat_n_q;
    done_d     = 1'b0;
    // A row outside RUN is dropped and flagged until reset.
    err_d      = err_q | (bus.row_valid && (state_q != ST_RUN));

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          last_m_d = bus.cfg_last_m;
          last_n_d = bus.cfg_last_n;
          row_d    = '0;
          n_d      = '0;
          m_d      = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.row_valid) begin
          wr_en_d    = 1'b1;
          sub_row_d  = row_q;
          submat_n_d = n_q;
          submat_m_d = m_q;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (n_q == last_n_q) begin
              n_d = '0;
              if (m_q == last_m_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                m_d = m_q + M_W'(1);
              end
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      n_q        <= '0;
      m_q        <= '0;
      last_m_q   <= '0;
      last_n_q   <= '0;
      wr_en_q    <= 1'b0;
      sub_row_q  <= '0;
      submat_m_q <= '0;
      submat_n_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      n_q        <= n_d;
      m_q        <= m_d;
      last_m_q   <= last_m_d;
      last_n_q   <= last_n_d;
      wr_en_q    <= wr_en_d;
      sub_row_q  <= sub_row_d;
      submat_m_q <= submat_m_d;
      submat_n_q <= submat_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.sub_row  = sub_row_q;
  assign bus.submat_m = submat_m_q;
  assign bus.submat_n = submat_n_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule
